// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: issues one aligned load/store and formats load data.
// Optional feature: define MEM_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES cycles without dmem_ack.
module mem_access_ctrl #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [6:0]  opcode_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] wdata_in,
   output logic        stall_out,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic [31:0] load_data_out,
   output logic        load_valid_out,
   output logic        misalign_out,
   output logic        timeout_out
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t      state_q, state_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] ld_data_q, ld_data_d;
   logic        ld_vld_q, ld_vld_d;
   logic        mis_q, mis_d;
   logic        tmo_hit;

   logic        is_load, is_store, memop;
   logic        sz_byte, sz_half, misaligned, accept;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [31:0] rd_shift;
   logic [31:0] ld_fmt;

   assign is_load    = valid_in && (opcode_in == OP_LOAD);
   assign is_store   = valid_in && (opcode_in == OP_STORE);
   assign memop      = is_load || is_store;
   // funct3[1:0] of 10 and 11 both decode as word, so undefined encodings fall back to word size
   assign sz_byte    = (funct3_in[1:0] == 2'b00);
   assign sz_half    = (funct3_in[1:0] == 2'b01);
   assign misaligned = (sz_half && addr_in[0]) || (!sz_byte && !sz_half && (addr_in[1:0] != 2'b00));
   assign accept     = (state_q != BUSY) && memop && !misaligned;

   always_comb begin
      be_new    = 4'b1111;
      wdata_new = wdata_in;
      if (is_store) begin
         if (sz_byte) begin
            be_new    = 4'b0001 << addr_in[1:0];
            wdata_new = {4{wdata_in[7:0]}};
         end else if (sz_half) begin
            be_new    = addr_in[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{wdata_in[15:0]}};
         end
      end
   end

   // Lane select uses the offset captured at issue, since addr_in may change while BUSY
   assign rd_shift = dmem_rdata >> {off_q, 3'b000};

   always_comb begin
      case (f3_q)
         3'b000:  ld_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b001:  ld_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
         3'b100:  ld_fmt = {24'd0, rd_shift[7:0]};
         3'b101:  ld_fmt = {16'd0, rd_shift[15:0]};
         default: ld_fmt = dmem_rdata;
      endcase
   end

`ifdef MEM_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q;

   assign tmo_hit = (state_q == BUSY) && !dmem_ack && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_d = '0;
      if (state_q == BUSY && state_d == BUSY) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_hit;
      end
   end

   assign timeout_out = tmo_q;
`else
   assign tmo_hit     = 1'b0;
   assign timeout_out = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      f3_d      = f3_q;
      off_d     = off_q;
      ld_data_d = ld_data_q;
      ld_vld_d  = 1'b0;
      mis_d     = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (memop && misaligned) begin
               mis_d = 1'b1;
            end else if (accept) begin
               state_d = BUSY;
               req_d   = 1'b1;
               we_d    = is_store;
               addr_d  = {addr_in[31:2], 2'b00};
               wdata_d = wdata_new;
               be_d    = be_new;
               f3_d    = funct3_in;
               off_d   = addr_in[1:0];
            end
         end
         BUSY: begin
            if (dmem_ack) begin
               state_d = DONE;
               req_d   = 1'b0;
               if (!we_q) begin
                  ld_data_d = ld_fmt;
                  ld_vld_d  = 1'b1;
               end
            end else if (tmo_hit) begin
               state_d = IDLE;
               req_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         f3_q      <= '0;
         off_q     <= '0;
         ld_data_q <= '0;
         ld_vld_q  <= 1'b0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         f3_q      <= f3_d;
         off_q     <= off_d;
         ld_data_q <= ld_data_d;
         ld_vld_q  <= ld_vld_d;
         mis_q     <= mis_d;
      end
   end

   assign stall_out      = accept || ((state_q == BUSY) && !dmem_ack);
   assign dmem_req       = req_q;
   assign dmem_we        = we_q;
   assign dmem_addr      = addr_q;
   assign dmem_wdata     = wdata_q;
   assign dmem_be        = be_q;
   assign load_data_out  = ld_data_q;
   assign load_valid_out = ld_vld_q;
   assign misalign_out   = mis_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum BUSY cycles before abort; it is used only with MEM_TIMEOUT_EN.
REQ-002 The block SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 The block SHALL have port valid_in  in  1  the EX/MEM stage holds a valid instruction.
REQ-005 The block SHALL have port opcode_in  in  7  EX/MEM opcode.
REQ-006 The block SHALL have port funct3_in  in  3  EX/MEM funct3, giving access size and sign.
REQ-007 The block SHALL have port addr_in  in  32  EX/MEM ALU result (c), the byte address.
REQ-008 The block SHALL have port wdata_in  in  32  EX/MEM store data (b).
REQ-009 The block SHALL have port stall_out  out  1  hold the IF..EX/MEM pipeline registers.
REQ-010 The block SHALL have ports dmem_req, dmem_we  out  1 each  request and write strobe to data memory.
REQ-011 The block SHALL have ports dmem_addr and dmem_wdata  out  32 each, and dmem_be  out  4: word address with [1:0]=0, lane-replicated data, byte enables.
REQ-012 The block SHALL have ports dmem_ack  in  1 and dmem_rdata  in  32: completion strobe and read word.
REQ-013 The block SHALL have ports load_data_out  out  32 and load_valid_out  out  1: formatted load result and its one-cycle qualifier.
REQ-014 The block SHALL have ports misalign_out and timeout_out  out  1 each: one-cycle error pulses.

Function
REQ-015 A memory op SHALL be valid_in=1 with opcode 0000011 (load) or 0100011 (store); every other opcode is ignored.
REQ-016 Misalignment SHALL be: halfword access with addr[0]=1, or word access with addr[1:0]!=0.
REQ-017 The FSM SHALL have states IDLE, BUSY and DONE; DONE SHALL behave as IDLE for new ops.
REQ-018 In IDLE/DONE, an aligned memop SHALL transition the FSM to BUSY on the next edge, registering req=1, we=store, addr, be and wdata.
REQ-019 In IDLE/DONE, a misaligned memop SHALL issue no request, SHALL pulse misalign_out=1 the next cycle, and SHALL NOT stall.
REQ-020 stall_out SHALL equal (IDLE or DONE)&aligned memop, OR BUSY&!dmem_ack; it is combinational.
REQ-021 In BUSY, dmem_ack=1 SHALL deassert req on the next edge and transition the FSM to DONE; for loads the block SHALL register the formatted rdata and set load_valid_out=1 for exactly the DONE cycle.
REQ-022 Byte enables: SB SHALL drive 0001<<addr[1:0], SH SHALL drive 0011<<(2*addr[1]), SW SHALL drive 1111; wdata SHALL be byte/halfword-replicated across lanes.
REQ-023 Load format SHALL select lane by addr[1:0]: LB/LH sign-extend, LBU/LHU zero-extend, LW passes 32 bits.
REQ-024 Loads SHALL drive be=1111.
REQ-025 dmem_ack outside BUSY SHALL be ignored.
REQ-026 Request outputs SHALL stay stable while BUSY regardless of input changes.
REQ-027 Minimum latency: op seen at cycle N, req at N+1, ack at N+1 releases the stall in cycle N+1, and load_valid_out is 1 at N+2.
REQ-028 Undefined funct3 on a memop SHALL be treated as word size.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE and drive req=0, we=0, be=0, addr=0, wdata=0, load_data_out=0, load_valid_out=0, misalign_out=0, timeout_out=0 and the counter to 0; stall_out then follows REQ-020.
REQ-030 Reset asserted mid-BUSY SHALL abandon the transaction, with no late completion.

Configuration
REQ-031 With MEM_TIMEOUT_EN defined, a counter SHALL count BUSY cycles; if TIMEOUT_CYCLES cycles pass without ack, the block SHALL drop req, pulse timeout_out for one cycle, return to IDLE with load_valid_out=0, and release the stall.
REQ-032 Without MEM_TIMEOUT_EN, BUSY SHALL wait indefinitely, timeout_out SHALL be tied 0, and no counter logic SHALL be present.

Verification
REQ-033 LW at addr 0x100 with ack one cycle after req and rdata=0xDEADBEEF -> stall for 2 cycles, load_data_out=0xDEADBEEF, load_valid_out pulse.
REQ-034 LB at addr 0x103 with rdata=0x80112233 -> load_data_out=0xFFFFFF80; LBU -> 0x00000080.
REQ-035 SH at addr 0x202 with b=0x0000ABCD -> be=1100, wdata=0xABCDABCD, we=1, dmem_addr=0x200.
REQ-036 LW at addr 0x101 -> no dmem_req, misalign_out pulse, stall_out=0.
REQ-037 rst asserted on the 3rd BUSY cycle, then a late ack -> req=0 at once, state IDLE, no load_valid_out pulse.
REQ-038 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4 and no ack -> req drops after 4 BUSY cycles, timeout_out pulse, stall released.
